design_select_sequencer: RTL and testbench
==========================================

// Module: design_select_sequencer
// PURPOSE
//   Parametrised successor to the fixed 64-slot design multiplexer: routes shared chip IO to one of
//   NUM_DES student designs and owns a per-design reset. Design switches use a handshaked request and
//   a sequenced isolate -> reset -> settle FSM, so the newly selected design always starts from a clean
//   reset and no glitches reach the pads. Optional input synchroniser with parametrised depth.
// PARAMETERS
//   NUM_DES      64            number of design slots (any value 2..64)
//   IO_W         12            per-design IO width
//   SEL_W        $clog2(NUM_DES)  select width
//   SYNC_STAGES  2             flop stages on io_in/user_reset when sync_inputs=1 (>=2)
//   RST_CYCLES   4             cycles des_reset of new design is held high during a switch (>=1)
//   SETTLE_CYCLES 2            cycles after reset release before outputs are un-gated (>=1)
// PORTS
//   clock            in   1               single clock
//   reset_n          in   1               asynchronous, active-low reset
//   io_in            in   IO_W            chip input pins
//   io_out           out  IO_W            chip output pins (registered)
//   user_reset       in   1               active-high soft reset request for the active design
//   sync_inputs      in   1               1: io_in/user_reset pass through SYNC_STAGES flops; 0: direct
//   hold_if_not_sel  in   1               1: non-selected designs held in reset
//   des_sel          in   SEL_W           requested slot
//   sel_valid        in   1               switch request; accepted when sel_valid && sel_ready
//   sel_ready        out  1               1 only in ACTIVE
//   sel_err          out  1               1-cycle pulse: accepted request had des_sel >= NUM_DES
//   busy             out  1               1 in any state other than ACTIVE
//   active_sel       out  SEL_W           slot currently owning the IO
//   des_io_in        out  NUM_DES*IO_W    flattened per-design inputs, slot i at [i*IO_W +: IO_W]
//   des_io_out       in   NUM_DES*IO_W    flattened per-design outputs
//   des_reset        out  NUM_DES         per-design active-high reset
// BEHAVIOUR
// - Reset (reset_n=0): state RST, active_sel=0, counter=RST_CYCLES-1, io_out=0, sel_ready=0, busy=1,
//   sel_err=0, sync flops=0, des_reset=all ones. On release, slot 0 completes RST->SETTLE->ACTIVE.
// - FSM: ACTIVE, ISOLATE, RST, SETTLE.
//   ACTIVE: accept on sel_valid&&sel_ready. des_sel<NUM_DES -> latch target, go ISOLATE (des_sel equal
//     to active_sel is legal = re-reset of same slot). des_sel>=NUM_DES -> stay ACTIVE, sel_err=1 next cycle.
//   ISOLATE: exactly 1 cycle; io_out gated to 0, active design inputs zeroed. Next: active_sel<=target,
//     RST with counter=RST_CYCLES-1.
//   RST: des_reset[active_sel]=1, inputs zeroed; counter decrements; at 0 -> SETTLE (counter=SETTLE_CYCLES-1).
//   SETTLE: des_reset[active_sel]=0, inputs routed, io_out still 0; at counter 0 -> ACTIVE.
// - Switch latency: acceptance edge T; busy=1 from T+1; ACTIVE entered 1+RST_CYCLES+SETTLE_CYCLES cycles
//   after T (7 with defaults); sel_valid ignored while busy.
// - Input path: in_q = sync_inputs ? io_in after SYNC_STAGES flops : io_in (combinational select, switch
//   of sync_inputs takes effect immediately, no flush). des_io_in[active_sel] = in_q in SETTLE/ACTIVE, else 0.
//   Non-selected slots: des_io_in = 0 always.
// - des_reset[i], i != active_sel: = hold_if_not_sel. des_reset[active_sel] in ACTIVE: = user_reset path
//   (synchronised like io_in); user_reset does not change FSM state.
// - io_out: registered, io_out <= (state==ACTIVE) ? des_io_out[active_sel] : 0; one-cycle latency.
// - Slots >= NUM_DES do not exist; no X may reach io_out for any des_sel value.
// - reset_n mid-switch: abandon target, restart reset sequence on slot 0 as above.
// TESTING
// 1 Reset release, des_io_out[0]=12'hABC: busy=1 for 1+3... exactly RST_CYCLES+SETTLE_CYCLES=6 cycles, then
//   sel_ready=1, io_out=12'hABC one cycle after ACTIVE; des_reset[0] high 4 cycles after release.
// 2 Switch to slot 17 (des_io_out[17]=12'h5A5): io_out=0 through sequence, des_reset[17] high exactly 4
//   cycles, ACTIVE 7 cycles after accept, then io_out=12'h5A5, active_sel=17.
// 3 NUM_DES=40, request des_sel=45: sel_err pulses 1 cycle, active_sel unchanged, busy stays 0.
// 4 sync_inputs=1, io_in 0->12'h3C3: des_io_in[active] changes 2 cycles later; sync_inputs=0: same cycle.
// 5 hold_if_not_sel=1 -> all des_reset except active = 1; =0 -> 0; user_reset=1 in ACTIVE (sync on) ->
//   des_reset[active]=1 after 2 cycles, state stays ACTIVE.
// 6 reset_n asserted in RST of a switch to slot 9: all outputs reset immediately; recovery targets slot 0.

Source files
------------

// File: rtl/design_select_sequencer_if.sv
// Design-select handshake between a controller and design_select_sequencer.
// The controller drives the request; the sequencer reports progress and the owning slot.
interface design_select_sequencer_if #(
  parameter int SEL_W = 6
);
  logic [SEL_W-1:0] des_sel;
  logic             sel_valid;
  logic             sel_ready;
  logic             sel_err;
  logic             busy;
  logic [SEL_W-1:0] active_sel;

  modport master (
    output des_sel, sel_valid,
    input  sel_ready, sel_err, busy, active_sel
  );

  modport slave (
    input  des_sel, sel_valid,
    output sel_ready, sel_err, busy, active_sel
  );
endinterface

// File: rtl/design_select_sequencer.sv
// Routes shared chip IO to one of NUM_DES designs. A design switch runs isolate -> reset -> settle
// so the new design always starts from a clean reset and the pads never see a partial switch.
module design_select_sequencer #(
  parameter int NUM_DES       = 64,
  parameter int IO_W          = 12,
  parameter int SEL_W         = $clog2(NUM_DES),
  parameter int SYNC_STAGES   = 2,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [IO_W-1:0]         io_in,
  output logic [IO_W-1:0]         io_out,
  input  logic                    user_reset,
  input  logic                    sync_inputs,
  input  logic                    hold_if_not_sel,
  design_select_sequencer_if.slave sel_if,
  output logic [NUM_DES*IO_W-1:0] des_io_in,
  input  logic [NUM_DES*IO_W-1:0] des_io_out,
  output logic [NUM_DES-1:0]      des_reset
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_LIMIT   = (SEL_W + 1)'(NUM_DES);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_ISOLATE,
    ST_RST,
    ST_SETTLE
  } state_e;

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [SEL_W-1:0]                  active_sel_q, active_sel_d;
  logic [SEL_W-1:0]                  target_q, target_d;
  logic                              sel_err_q, sel_err_d;
  logic [IO_W-1:0]                   io_out_q, io_out_d;
  logic [SYNC_STAGES-1:0][IO_W:0]    sync_q;

  logic [IO_W:0]   raw_in;
  logic [IO_W:0]   in_sel;
  logic            req_legal;
  logic            route_in;
  logic            active_rst;
  logic [IO_W-1:0] active_out;

  // user_reset rides in the top bit so it shares the io_in synchroniser
  assign raw_in    = {user_reset, io_in};
  assign in_sel    = sync_inputs ? sync_q[SYNC_STAGES-1] : raw_in;
  assign req_legal = ({1'b0, sel_if.des_sel} < NUM_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RST;
      cnt_q        <= RST_LOAD;
      active_sel_q <= '0;
      target_q     <= '0;
      sel_err_q    <= 1'b0;
      io_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_sel_q <= active_sel_d;
      target_q     <= target_d;
      sel_err_q    <= sel_err_d;
      io_out_q     <= io_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_sel_d = active_sel_q;
    target_d     = target_q;
    sel_err_d    = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (sel_if.sel_valid) begin
          if (req_legal) begin
            target_d = sel_if.des_sel;
            state_d  = ST_ISOLATE;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      ST_ISOLATE: begin
        active_sel_d = target_q;
        cnt_d        = RST_LOAD;
        state_d      = ST_RST;
      end
      ST_RST: begin
        if (cnt_q == '0) begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    route_in = (state_q == ST_SETTLE) || (state_q == ST_ACTIVE);
    case (state_q)
      ST_RST:    active_rst = 1'b1;
      ST_SETTLE: active_rst = 1'b0;
      default:   active_rst = in_sel[IO_W];
    endcase
  end

  // Compare-based slot decode keeps every path X-free whatever active_sel holds
  always_comb begin
    des_io_in  = '0;
    des_reset  = '0;
    active_out = '0;
    for (int unsigned i = 0; i < NUM_DES; i++) begin
      if (active_sel_q == SEL_W'(i)) begin
        if (route_in) begin
          des_io_in[i*IO_W +: IO_W] = in_sel[IO_W-1:0];
        end
        des_reset[i] = active_rst;
        active_out   = des_io_out[i*IO_W +: IO_W];
      end else begin
        des_reset[i] = hold_if_not_sel;
      end
    end
    if (!reset_n) begin
      des_reset = '1;
    end
  end

  assign io_out_d = (state_q == ST_ACTIVE) ? active_out : '0;
  assign io_out   = io_out_q;

  assign sel_if.sel_ready  = (state_q == ST_ACTIVE);
  assign sel_if.busy       = (state_q != ST_ACTIVE);
  assign sel_if.sel_err    = sel_err_q;
  assign sel_if.active_sel = active_sel_q;

endmodule

// File: tb/tb_design_select_sequencer.sv
// Bench for design_select_sequencer: directed switch scenarios followed by random traffic,
// all checked against a cycle-age reference model of the switch sequence.
module tb_design_select_sequencer;

  localparam int NUM_DES       = 40;
  localparam int IO_W          = 12;
  localparam int SEL_W         = 6;
  localparam int RST_CYCLES    = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int PH_ACT = 0, PH_ISO = 1, PH_RST = 2, PH_SET = 3;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic [IO_W-1:0]         io_in = '0;
  logic [IO_W-1:0]         io_out;
  logic                    user_reset = 1'b0;
  logic                    sync_inputs = 1'b0;
  logic                    hold_if_not_sel = 1'b0;
  logic [NUM_DES*IO_W-1:0] des_io_in;
  logic [NUM_DES*IO_W-1:0] des_io_out = '0;
  logic [NUM_DES-1:0]      des_reset;

  always #5 clock = ~clock;

  design_select_sequencer_if #(.SEL_W(SEL_W)) sif ();

  design_select_sequencer #(
    .NUM_DES(NUM_DES), .IO_W(IO_W), .SEL_W(SEL_W), .SYNC_STAGES(2),
    .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .io_in(io_in), .io_out(io_out),
    .user_reset(user_reset), .sync_inputs(sync_inputs), .hold_if_not_sel(hold_if_not_sel),
    .sel_if(sif), .des_io_in(des_io_in), .des_io_out(des_io_out), .des_reset(des_reset)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a switch is described by its age in cycles since acceptance.
  int            m_age, m_old, m_new;
  logic          m_err;
  logic [IO_W-1:0] m_io;
  logic [IO_W:0] m_h0, m_h1;

  function automatic int phase_of(input int age);
    if (age <= 1) return PH_ISO;
    if (age <= RST_CYCLES + 1) return PH_RST;
    if (age <= RST_CYCLES + SETTLE_CYCLES + 1) return PH_SET;
    return PH_ACT;
  endfunction

  function automatic int eff_sel();
    return (m_age <= 1) ? m_old : m_new;
  endfunction

  task automatic model_reset();
    m_age = 2; m_old = 0; m_new = 0; m_err = 1'b0; m_io = '0; m_h0 = '0; m_h1 = '0;
  endtask

  task automatic model_edge();
    int ph, e;
    if (!reset_n) return;
    ph = phase_of(m_age);
    e  = eff_sel();
    m_io  = (ph == PH_ACT) ? des_io_out[e*IO_W +: IO_W] : '0;
    m_err = 1'b0;
    if (ph == PH_ACT && sif.sel_valid) begin
      if (int'(sif.des_sel) < NUM_DES) begin
        m_old = e; m_new = int'(sif.des_sel); m_age = 1;
      end else begin
        m_err = 1'b1;
        if (m_age < 1000) m_age++;
      end
    end else if (m_age < 1000) begin
      m_age++;
    end
    m_h1 = m_h0;
    m_h0 = {user_reset, io_in};
  endtask

  task automatic check_outputs();
    int ph, e;
    logic [IO_W:0]           in_eff;
    logic [NUM_DES*IO_W-1:0] e_in;
    logic [NUM_DES-1:0]      e_rst;
    ph = phase_of(m_age);
    e  = eff_sel();
    in_eff = sync_inputs ? m_h1 : {user_reset, io_in};
    e_in = '0;
    if (ph == PH_SET || ph == PH_ACT) e_in[e*IO_W +: IO_W] = in_eff[IO_W-1:0];
    for (int i = 0; i < NUM_DES; i++) begin
      if (i == e) e_rst[i] = (ph == PH_RST) ? 1'b1 : (ph == PH_SET) ? 1'b0 : in_eff[IO_W];
      else        e_rst[i] = hold_if_not_sel;
    end
    if (!reset_n) e_rst = '1;
    check("busy", sif.busy, ph != PH_ACT);
    check("sel_ready", sif.sel_ready, ph == PH_ACT);
    check("active_sel", sif.active_sel, e);
    check("sel_err", sif.sel_err, m_err);
    check("io_out", io_out, m_io);
    check("des_io_in", des_io_in, e_in);
    check("des_reset", des_reset, e_rst);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drive_reset(input logic v);
    reset_n = v;
    if (!v) model_reset();
  endtask

  initial begin
    int nb, nr, lat;
    logic [NUM_DES-1:0] exp_rst;
    sif.des_sel = '0;
    sif.sel_valid = 1'b0;
    model_reset();
    repeat (2) step();

    // Reset release: slot 0 comes up through the full sequence
    des_io_out[0 +: IO_W] = 12'hABC;
    drive_reset(1'b1);
    #1;
    nb = sif.busy ? 1 : 0;
    nr = des_reset[0] ? 1 : 0;
    for (int k = 0; k < 20 && sif.busy; k++) begin
      step();
      if (sif.busy) nb++;
      if (des_reset[0]) nr++;
    end
    check("t1_busy_cycles", nb, 6);
    check("t1_rst_cycles", nr, 4);
    step();
    check("t1_io_out", io_out, 12'hABC);

    // Switch to slot 17
    des_io_out[17*IO_W +: IO_W] = 12'h5A5;
    sif.des_sel = 6'd17;
    sif.sel_valid = 1'b1;
    step();
    sif.sel_valid = 1'b0;
    lat = 0;
    nr = des_reset[17] ? 1 : 0;
    for (int k = 0; k < 30 && sif.busy; k++) begin
      step();
      lat++;
      if (des_reset[17]) nr++;
    end
    check("t2_latency", lat, 7);
    check("t2_rst_cycles", nr, 4);
    step();
    check("t2_io_out", io_out, 12'h5A5);
    check("t2_active_sel", sif.active_sel, 17);

    // Out-of-range request
    sif.des_sel = 6'd45;
    sif.sel_valid = 1'b1;
    step();
    sif.sel_valid = 1'b0;
    check("t3_err_pulse", sif.sel_err, 1'b1);
    check("t3_busy", sif.busy, 1'b0);
    check("t3_active_sel", sif.active_sel, 17);
    step();
    check("t3_err_clear", sif.sel_err, 1'b0);

    // Synchronised versus direct input path
    sync_inputs = 1'b1;
    io_in = '0;
    repeat (3) step();
    io_in = 12'h3C3;
    step();
    check("t4_sync_early", des_io_in[17*IO_W +: IO_W], 12'h000);
    step();
    check("t4_sync_late", des_io_in[17*IO_W +: IO_W], 12'h3C3);
    sync_inputs = 1'b0;
    io_in = '0;
    #1;
    check("t4_direct_zero", des_io_in[17*IO_W +: IO_W], 12'h000);
    io_in = 12'h3C3;
    #1;
    check("t4_direct_val", des_io_in[17*IO_W +: IO_W], 12'h3C3);

    // Hold of non-selected slots and user soft reset
    hold_if_not_sel = 1'b1;
    #1;
    exp_rst = '1;
    exp_rst[17] = 1'b0;
    check("t5_hold_on", des_reset, exp_rst);
    hold_if_not_sel = 1'b0;
    #1;
    check("t5_hold_off", des_reset, '0);
    user_reset = 1'b1;
    sync_inputs = 1'b1;
    step();
    check("t5_user_early", des_reset[17], 1'b0);
    step();
    check("t5_user_late", des_reset[17], 1'b1);
    check("t5_still_active", sif.busy, 1'b0);
    user_reset = 1'b0;
    repeat (2) step();

    // reset_n during the RST phase of a switch to slot 9
    sif.des_sel = 6'd9;
    sif.sel_valid = 1'b1;
    step();
    sif.sel_valid = 1'b0;
    repeat (2) step();
    check("t6_in_switch", sif.active_sel, 9);
    drive_reset(1'b0);
    #1;
    check("t6_busy", sif.busy, 1'b1);
    check("t6_ready", sif.sel_ready, 1'b0);
    check("t6_io_out", io_out, '0);
    check("t6_des_reset", des_reset, {NUM_DES{1'b1}});
    check("t6_active_sel", sif.active_sel, 0);
    repeat (2) step();
    drive_reset(1'b1);
    for (int k = 0; k < 30 && sif.busy; k++) step();
    check("t6_recover_sel", sif.active_sel, 0);
    check("t6_recover_busy", sif.busy, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      io_in = IO_W'($urandom);
      user_reset = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) sync_inputs = ~sync_inputs;
      if ($urandom_range(0, 15) == 0) hold_if_not_sel = ~hold_if_not_sel;
      sif.sel_valid = ($urandom_range(0, 3) == 0);
      sif.des_sel = SEL_W'($urandom_range(0, 63));
      for (int i = 0; i < NUM_DES; i++) des_io_out[i*IO_W +: IO_W] = IO_W'($urandom);
      if ($urandom_range(0, 299) == 0) drive_reset(1'b0);
      else if (!reset_n) drive_reset(1'b1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
